game_session_ctrl: RTL and testbench

Session sequencer for the dino game. It owns the IDLE/RUN/PAUSE/OVER state machine and gates the per-frame stopwatch, producing a BCD mm:ss elapsed time. It also keeps a best-time record and selects which time the seven-segment driver shows. It sits between the debounced button pulses, the game logic's collision flag and the VGA vsync on one side, and `dino_logic`'s run enable, the LEDs and `SevenSegment.nums` on the other.

---
 rtl/dino_pkg.sv | 15 +
 rtl/bcd_mmss_counter.sv | 46 ++++
 rtl/game_session_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_session_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game session control path.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // BCD {min_tens, min_ones, sec_tens, sec_ones}
  localparam logic [15:0] BCD_TIME_MAX  = 16'h9959;
  localparam logic [15:0] BCD_TIME_ZERO = 16'h0000;

endpackage

// File: rtl/bcd_mmss_counter.sv
// BCD mm:ss counter: synchronous clear, one-second increment, saturates at 99:59.
module bcd_mmss_counter
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] value
);

  logic [15:0] value_next;

  // Carry chain: sec_ones 9->0, sec_tens 5->0, min_ones 9->0, min_tens up
  always_comb begin
    value_next = value;
    if (value[3:0] != 4'd9) begin
      value_next[3:0] = value[3:0] + 4'd1;
    end else begin
      value_next[3:0] = 4'd0;
      if (value[7:4] != 4'd5) begin
        value_next[7:4] = value[7:4] + 4'd1;
      end else begin
        value_next[7:4] = 4'd0;
        if (value[11:8] != 4'd9) begin
          value_next[11:8] = value[11:8] + 4'd1;
        end else begin
          value_next[11:8]  = 4'd0;
          value_next[15:12] = value[15:12] + 4'd1;
        end
      end
    end
  end

  // Time register; the max check keeps min_tens from ever passing 9
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= BCD_TIME_ZERO;
    end else if (clear) begin
      value <= BCD_TIME_ZERO;
    end else if (inc && (value != BCD_TIME_MAX)) begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/game_session_ctrl.sv
// Session sequencer: IDLE/RUN/PAUSE/OVER FSM, vsync-driven stopwatch,
// best-time record and seven-segment source selection.
// Optional feature macro: GAME_BEST_TIME_EN (best time + display alternation).
module game_session_ctrl
  import dino_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ALT_FRAMES     = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_pulse,
  input  logic        pause_pulse,
  input  logic        collision,
  input  logic        vsync,
  output logic        game_active,
  output logic        paused,
  output logic        game_over,
  output logic [15:0] cur_time,
  output logic [15:0] best_time,
  output logic [15:0] disp_nums,
  output logic        disp_best
);

  localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);

  state_t state, next_state;
  logic   vsync_p0, vsync_p1, vsync_p2;
  logic   tick;
  logic   clear_time;
  logic   count_tick;
  logic   sec_inc;
  logic [FRAME_W-1:0] frame_cnt;

  // Two-flop synchronizer followed by an edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p0 <= 1'b0;
      vsync_p1 <= 1'b0;
      vsync_p2 <= 1'b0;
    end else begin
      vsync_p0 <= vsync;
      vsync_p1 <= vsync_p0;
      vsync_p2 <= vsync_p1;
    end
  end

  assign tick = vsync_p1 & ~vsync_p2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state; collision outranks pause in RUN and drops a coincident tick
  always_comb begin
    next_state = state;
    clear_time = 1'b0;
    count_tick = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_pulse) begin
          clear_time = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (collision) begin
          next_state = ST_OVER;
        end else begin
          count_tick = tick;
          if (pause_pulse) next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_pulse || start_pulse) next_state = ST_RUN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Frame counter; wraps every second and keeps wrapping after saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (clear_time) begin
      frame_cnt <= '0;
    end else if (count_tick) begin
      if (frame_cnt == FRAME_LAST) frame_cnt <= '0;
      else                         frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign sec_inc = count_tick && (frame_cnt == FRAME_LAST);

  bcd_mmss_counter u_time (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_time),
    .inc   (sec_inc),
    .value (cur_time)
  );

  assign game_active = (state == ST_RUN);
  assign paused      = (state == ST_PAUSE);
  assign game_over   = (state == ST_OVER);

`ifdef GAME_BEST_TIME_EN
  localparam int ALT_W = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;
  localparam logic [ALT_W-1:0] ALT_LAST = ALT_W'(ALT_FRAMES - 1);

  logic [15:0]      best_q;
  logic             disp_q;
  logic [ALT_W-1:0] alt_cnt;

  // Best time loads on the edge that leaves RUN for OVER; BCD compares as unsigned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= BCD_TIME_ZERO;
    end else if ((state == ST_RUN) && collision && (cur_time > best_q)) begin
      best_q <= cur_time;
    end
  end

  // Display alternation: held clear in RUN/PAUSE, toggles every ALT_FRAMES ticks otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alt_cnt <= '0;
      disp_q  <= 1'b0;
    end else if ((next_state == ST_RUN) || (next_state == ST_PAUSE)) begin
      alt_cnt <= '0;
      disp_q  <= 1'b0;
    end else if (tick && ((state == ST_IDLE) || (state == ST_OVER))) begin
      if (alt_cnt == ALT_LAST) begin
        alt_cnt <= '0;
        disp_q  <= ~disp_q;
      end else begin
        alt_cnt <= alt_cnt + 1'b1;
      end
    end
  end

  assign best_time = best_q;
  assign disp_best = disp_q;
  assign disp_nums = disp_q ? best_q : cur_time;
`else
  assign best_time = BCD_TIME_ZERO;
  assign disp_best = 1'b0;
  assign disp_nums = cur_time;
`endif

endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl with a cur_time scoreboard.
module tb_game_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_pulse, pause_pulse, collision, vsync;
  logic        game_active, paused, game_over, disp_best;
  logic [15:0] cur_time, best_time, disp_nums;

  logic        c_clear, c_inc;
  logic [15:0] c_value;

  int total = 0;
  int bad   = 0;

  // Scoreboard and reference model
  logic [15:0] exp_q[$];
  int m_state;   // 0 idle, 1 run, 2 pause, 3 over
  int m_frames, m_secs, m_alt;
  bit m_disp;
  int m_best;

`ifdef GAME_BEST_TIME_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  game_session_ctrl #(.FRAMES_PER_SEC(60), .ALT_FRAMES(120)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pulse (start_pulse),
    .pause_pulse (pause_pulse),
    .collision   (collision),
    .vsync       (vsync),
    .game_active (game_active),
    .paused      (paused),
    .game_over   (game_over),
    .cur_time    (cur_time),
    .best_time   (best_time),
    .disp_nums   (disp_nums),
    .disp_best   (disp_best)
  );

  bcd_mmss_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (c_clear),
    .inc   (c_inc),
    .value (c_value)
  );

  function automatic logic [15:0] to_bcd(input int s);
    int mins, secs;
    mins = s / 60;
    secs = s % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
  endfunction

  function automatic logic [15:0] exp_best();
    return BEST_EN ? to_bcd(m_best) : 16'h0000;
  endfunction

  function automatic logic [15:0] exp_disp();
    return (BEST_EN && m_disp) ? to_bcd(m_best) : to_bcd(m_secs);
  endfunction

  task automatic model_reset();
    m_state = 0; m_frames = 0; m_secs = 0; m_alt = 0; m_disp = 0; m_best = 0;
    exp_q.delete();
  endtask

  task automatic model_start();
    m_state = 1; m_frames = 0; m_secs = 0; m_alt = 0; m_disp = 0;
  endtask

  task automatic model_collide();
    if (m_secs > m_best) m_best = m_secs;
    m_state = 3; m_alt = 0; m_disp = 0;
  endtask

  // One vsync pulse (3 high, 3 low); optional collision/pause aligned with the tick
  task automatic pulse(input bit with_coll, input bit with_pause);
    logic [15:0] e;
    if (m_state == 1 && !with_coll) begin
      m_frames++;
      if (m_frames == 60) begin
        m_frames = 0;
        if (m_secs < 5999) m_secs++;
      end
    end else if (m_state == 0 || m_state == 3) begin
      m_alt++;
      if (m_alt == 120) begin m_alt = 0; m_disp = ~m_disp; end
    end
    exp_q.push_back(to_bcd(m_secs));
    vsync = 1'b1;
    @(negedge clk); @(negedge clk);
    collision = with_coll; pause_pulse = with_pause;
    @(negedge clk);
    collision = 1'b0; pause_pulse = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    if (with_coll && m_state == 1) model_collide();
    else if (with_pause && m_state == 1) m_state = 2;
    e = exp_q.pop_front();
    total++;
    if (cur_time !== e) begin
      bad++;
      $display("FAIL cur_time_sb: got %h want %h", cur_time, e);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0);
  endtask

  task automatic press(input bit s, input bit p);
    start_pulse = s; pause_pulse = p;
    @(negedge clk);
    start_pulse = 1'b0; pause_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_pulse = 0; pause_pulse = 0; collision = 0; vsync = 0;
    c_clear = 0; c_inc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({game_active, paused, game_over, cur_time, best_time, disp_nums, disp_best} !== 52'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b %b %b %h %h %h %b want all zero",
               game_active, paused, game_over, cur_time, best_time, disp_nums, disp_best);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run_count();
    press(1'b1, 1'b0);
    model_start();
    total++;
    if (game_active !== 1'b1 || cur_time !== 16'h0000) begin
      bad++;
      $display("FAIL start_run: got active=%b time=%h want 1 0000", game_active, cur_time);
    end
    pulses(60);
    total++;
    if (cur_time !== 16'h0001) begin
      bad++;
      $display("FAIL one_second: got %h want 0001", cur_time);
    end
    pulses(3539);
    total++;
    if (cur_time !== 16'h0059) begin
      bad++;
      $display("FAIL before_minute: got %h want 0059", cur_time);
    end
    pulses(1);
    total++;
    if (cur_time !== 16'h0100) begin
      bad++;
      $display("FAIL minute_carry: got %h want 0100", cur_time);
    end
    pulses(60);
    total++;
    if (cur_time !== 16'h0101 || game_active !== 1'b1) begin
      bad++;
      $display("FAIL after_3660: got %h active=%b want 0101 1", cur_time, game_active);
    end
  endtask

  task automatic test_pause();
    logic [15:0] held;
    pulses(30);
    pulse(1'b0, 1'b1);
    held = cur_time;
    total++;
    if (paused !== 1'b1 || game_active !== 1'b0) begin
      bad++;
      $display("FAIL pause_enter: got paused=%b active=%b want 1 0", paused, game_active);
    end
    pulses(120);
    total++;
    if (paused !== 1'b1 || cur_time !== held) begin
      bad++;
      $display("FAIL pause_hold: got paused=%b time=%h want 1 %h", paused, cur_time, held);
    end
    collision = 1'b1; @(negedge clk); collision = 1'b0;
    total++;
    if (paused !== 1'b1) begin
      bad++;
      $display("FAIL pause_ignores_collision: got paused=%b want 1", paused);
    end
    press(1'b0, 1'b1);
    m_state = 1;
    total++;
    if (game_active !== 1'b1) begin
      bad++;
      $display("FAIL resume: got active=%b want 1", game_active);
    end
    press(1'b1, 1'b0);
    total++;
    if (game_active !== 1'b1 || cur_time !== held) begin
      bad++;
      $display("FAIL start_ignored_in_run: got active=%b time=%h want 1 %h", game_active, cur_time, held);
    end
    pulses(30);
    total++;
    if (cur_time !== 16'h0102) begin
      bad++;
      $display("FAIL resume_frame_count: got %h want 0102", cur_time);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({game_active, paused, game_over, cur_time, best_time, disp_nums, disp_best} !== 52'd0) begin
      bad++;
      $display("FAIL async_reset: got %b %b %b %h %h %h %b want all zero",
               game_active, paused, game_over, cur_time, best_time, disp_nums, disp_best);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    pulses(5);
    total++;
    if (game_active !== 1'b0 || cur_time !== 16'h0000 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got active=%b over=%b time=%h want 0 0 0000", game_active, game_over, cur_time);
    end
  endtask

  task automatic test_collision();
    press(1'b1, 1'b0);
    model_start();
    pulses(779);
    total++;
    if (cur_time !== 16'h0012) begin
      bad++;
      $display("FAIL pre_collision: got %h want 0012", cur_time);
    end
    pulse(1'b1, 1'b0);
    total++;
    if (game_over !== 1'b1 || game_active !== 1'b0 || cur_time !== 16'h0012) begin
      bad++;
      $display("FAIL collision_drop_tick: got over=%b active=%b time=%h want 1 0 0012", game_over, game_active, cur_time);
    end
    total++;
    if (best_time !== exp_best()) begin
      bad++;
      $display("FAIL best_first: got %h want %h", best_time, exp_best());
    end
  endtask

  task automatic test_back_to_back();
    press(1'b0, 1'b1);
    total++;
    if (game_over !== 1'b1 || paused !== 1'b0) begin
      bad++;
      $display("FAIL over_ignores_pause: got over=%b paused=%b want 1 0", game_over, paused);
    end
    press(1'b1, 1'b1);
    model_start();
    total++;
    if (game_active !== 1'b1 || cur_time !== 16'h0000 || disp_best !== 1'b0) begin
      bad++;
      $display("FAIL restart_start_wins: got active=%b time=%h db=%b want 1 0000 0", game_active, cur_time, disp_best);
    end
    pulses(300);
    collision = 1'b1; @(negedge clk); collision = 1'b0;
    model_collide();
    total++;
    if (game_over !== 1'b1 || cur_time !== 16'h0005 || best_time !== exp_best()) begin
      bad++;
      $display("FAIL second_session: got over=%b time=%h best=%h want 1 0005 %h", game_over, cur_time, best_time, exp_best());
    end
    total++;
    if (disp_best !== 1'b0 || disp_nums !== 16'h0005) begin
      bad++;
      $display("FAIL over_disp_start: got db=%b nums=%h want 0 0005", disp_best, disp_nums);
    end
    for (int k = 0; k < 2; k++) begin
      pulses(119);
      total++;
      if (disp_nums !== exp_disp()) begin
        bad++;
        $display("FAIL alt_before_%0d: got %h want %h", k, disp_nums, exp_disp());
      end
      pulses(1);
      total++;
      if (disp_best !== (BEST_EN & m_disp) || disp_nums !== exp_disp()) begin
        bad++;
        $display("FAIL alt_toggle_%0d: got db=%b nums=%h want %b %h", k, disp_best, disp_nums, BEST_EN & m_disp, exp_disp());
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    c_clear = 1'b1; @(negedge clk); c_clear = 1'b0;
    c_inc = 1'b1;
    for (int i = 1; i <= 6059; i++) begin
      @(negedge clk);
      n = (i > 5999) ? 5999 : i;
      if (i == 59 || i == 60 || i == 3600 || i == 5999 || i == 6059) begin
        total++;
        if (c_value !== to_bcd(n)) begin
          bad++;
          $display("FAIL sat_count_%0d: got %h want %h", i, c_value, to_bcd(n));
        end
      end
    end
    c_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_pause();
    test_async_reset();
    test_collision();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
